// File: rtl/vmem_pat_pkg.sv
// vmem_pat_pkg: mode and state encodings plus LFSR constants for the video memory pattern generator
package vmem_pat_pkg;
  typedef enum logic [2:0] {
    MODE_RAMP  = 3'd0,
    MODE_SOLID = 3'd1,
    MODE_CHECK = 3'd2,
    MODE_ADDR  = 3'd3,
    MODE_LFSR  = 3'd4
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  // right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/vmem_pat_lfsr.sv
// vmem_pat_lfsr: 16-bit pattern LFSR with seed load and per-write advance
module vmem_pat_lfsr
  import vmem_pat_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [15:0]       i_seed,
  output logic [DATA_W-1:0] o_data
);
  logic [15:0] lfsr_q, lfsr_d;
  // an all-zero seed would lock up the register, so it is swapped for the default
  always_comb lfsr_d = i_load ? (i_seed == 16'h0 ? LFSR_SEED : i_seed) : i_adv ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
  assign o_data = lfsr_q[DATA_W-1:0];
endmodule

// File: rtl/vmem_pat_gen.sv
// vmem_pat_gen: fills a video memory range with a selectable test pattern, one word per cycle
module vmem_pat_gen
  import vmem_pat_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 14,
  parameter int LINE_LOG2 = 6
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [2:0]        i_mode,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_fill,
  input  logic [1:0]        i_lane,
  input  logic              i_afull,
  output logic              o_wr_n,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_vmem_data,
  output logic              o_vmem_up_n,
  output logic              o_vmem_lo_n,
  output logic              o_busy,
  output logic              o_done
);
  state_e state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, cur_addr;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] fill_q, fill_d, ramp_q, ramp_d, data_q, data_d, pat, lfsr_data;
  logic [1:0] lane_q, lane_d;
  logic wr_n_q, wr_n_d, up_n_q, up_n_d, lo_n_q, lo_n_d;
  logic accept, issue;

  vmem_pat_lfsr #(.DATA_W(DATA_W)) u_lfsr (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (accept),
    .i_adv    (issue),
    .i_seed   (16'({i_fill, i_fill})),
    .o_data   (lfsr_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      lane_q  <= 2'b01;
      idx_q   <= '0;
      ramp_q  <= '0;
      wr_n_q  <= 1'b1;
      up_n_q  <= 1'b1;
      lo_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      ramp_q  <= ramp_d;
      wr_n_q  <= wr_n_d;
      up_n_q  <= up_n_d;
      lo_n_q  <= lo_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // abort wins over both completion and a pending write
  always_comb begin
    state_d = state_q == ST_IDLE ? (i_start ? ST_RUN : ST_IDLE)
            : state_q == ST_RUN  ? (i_abort ? ST_IDLE : idx_q == len_q ? ST_DONE : ST_RUN)
            : ST_IDLE;
  end

  always_comb begin
    accept   = state_q == ST_IDLE && i_start;
    issue    = state_q == ST_RUN && !i_abort && idx_q != len_q && !i_afull;
    cur_addr = base_q + ADDR_W'(idx_q);
    pat      = mode_q == MODE_RAMP  ? ramp_q
             : mode_q == MODE_CHECK ? ((idx_q[0] ^ idx_q[LINE_LOG2]) ? ~fill_q : fill_q)
             : mode_q == MODE_ADDR  ? cur_addr[DATA_W-1:0]
             : mode_q == MODE_LFSR  ? lfsr_data
             : fill_q;
    mode_d   = accept ? i_mode : mode_q;
    base_d   = accept ? i_base : base_q;
    len_d    = accept ? i_len : len_q;
    fill_d   = accept ? i_fill : fill_q;
    lane_d   = accept ? (i_lane == 2'b00 ? 2'b01 : i_lane) : lane_q;
    idx_d    = accept ? '0 : issue ? idx_q + LEN_W'(1) : idx_q;
    // ramp shifts in ones and restarts at a single bit once full, avoiding a modulo
    ramp_d   = accept ? DATA_W'(1) : issue ? (&ramp_q ? DATA_W'(1) : {ramp_q[DATA_W-2:0], 1'b1}) : ramp_q;
    wr_n_d   = !issue;
    up_n_d   = !(issue && lane_q[1]);
    lo_n_d   = !(issue && lane_q[0]);
    addr_d   = issue ? cur_addr : addr_q;
    data_d   = issue ? pat : data_q;
  end

  always_comb begin
    o_busy      = state_q == ST_RUN;
    o_done      = state_q == ST_DONE;
    o_wr_n      = wr_n_q;
    o_addr      = addr_q;
    o_vmem_data = data_q;
    o_vmem_up_n = up_n_q;
    o_vmem_lo_n = lo_n_q;
  end
endmodule

// File: tb/tb_vmem_pat_gen.sv
// tb_vmem_pat_gen: directed scoreboard bench for vmem_pat_gen
module tb_vmem_pat_gen;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, afull = 1'b0;
  logic [2:0] mode = '0;
  logic [15:0] base = '0;
  logic [13:0] len = '0;
  logic [7:0] fill = '0;
  logic [1:0] lane = '0;
  logic wr_n, up_n, lo_n, busy, done;
  logic [15:0] addr;
  logic [7:0] data;
  int n_chk = 0, n_fail = 0, n_strobe = 0, n_done = 0, n_busy = 0;
  int cyc = 0, first_cyc = -1, last_cyc = 0, done_cyc = 0;
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  vmem_pat_gen dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_base(base), .i_len(len), .i_fill(fill), .i_lane(lane), .i_afull(afull),
    .o_wr_n(wr_n), .o_addr(addr), .o_vmem_data(data), .o_vmem_up_n(up_n),
    .o_vmem_lo_n(lo_n), .o_busy(busy), .o_done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  task automatic push_run(input int m, input logic [15:0] b, input int n, input logic [7:0] f, input logic [1:0] ln);
    logic [15:0] s, a;
    logic [7:0] d;
    logic [1:0] el;
    s = {f, f};
    if (s == 16'h0) s = 16'hACE1;
    el = ln == 2'b00 ? 2'b01 : ln;
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i);
      case (m)
        0: d = 8'((9'h1 << (i % 8 + 1)) - 9'h1);
        2: d = (i[0] ^ i[6]) ? ~f : f;
        3: d = a[7:0];
        4: begin d = s[7:0]; s = lfsr_step(s); end
        default: d = f;
      endcase
      exp_q.push_back({a, d, ~el[1], ~el[0]});
    end
  endtask

  task automatic fill_go(input logic [2:0] m, input logic [15:0] b, input logic [13:0] n,
                         input logic [7:0] f, input logic [1:0] ln, input int npush);
    mode = m; base = b; len = n; fill = f; lane = ln;
    push_run(int'(m), b, npush, f, ln);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 400) begin @(negedge clk); #1; c++; end
    check(tag, done, 1);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (busy) n_busy++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (!wr_n) begin
      n_strobe++;
      last_cyc = cyc;
      if (first_cyc < 0) first_cyc = cyc;
      check("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("strobe", {addr, data, up_n, lo_n}, exp_q.pop_front());
    end else check("idle_lanes", {up_n, lo_n}, 2'b11);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_n", wr_n, 1);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_busy_done", {busy, done}, 0);
    rst_n = 1'b1;
    // ramp, full lanes, no backpressure
    n_strobe = 0; first_cyc = -1;
    fill_go(3'd0, 16'hC000, 14'd16, 8'h00, 2'b11, 16);
    wait_done("ramp_done");
    check("ramp_count", n_strobe, 16);
    check("ramp_consecutive", last_cyc - first_cyc, 15);
    check("ramp_done_lat", done_cyc - last_cyc, 1);
    // solid fill, upper lane only, afull toggling every 3 cycles
    n_strobe = 0;
    fill_go(3'd1, 16'h0100, 14'd20, 8'hA5, 2'b10, 20);
    c = 0;
    while (!done && c < 300) begin
      @(negedge clk); #1; c++;
      if (c % 3 == 0) afull = ~afull;
    end
    afull = 1'b0;
    check("afull_done", done, 1);
    check("afull_count", n_strobe, 20);
    check("afull_stalled", c > 25, 1);
    check("afull_drain", exp_q.size(), 0);
    // address mode across wrap, lane 00 defaults to lower lane
    fill_go(3'd3, 16'hFFFE, 14'd4, 8'h00, 2'b00, 4);
    wait_done("addr_wrap_done");
    // checkerboard spanning the line bit
    fill_go(3'd2, 16'h0200, 14'd130, 8'h3C, 2'b11, 130);
    wait_done("checker_done");
    // modes 5-7 behave as solid
    fill_go(3'd6, 16'h0400, 14'd3, 8'h5C, 2'b01, 3);
    wait_done("mode6_done");
    // zero length
    @(negedge clk); #1;
    n_strobe = 0; n_done = 0; n_busy = 0;
    fill_go(3'd0, 16'h1000, 14'd0, 8'h00, 2'b11, 0);
    wait_done("len0_done");
    repeat (2) @(negedge clk);
    #1;
    check("len0_strobes", n_strobe, 0);
    check("len0_busy", n_busy, 1);
    check("len0_done_pulses", n_done, 1);
    // abort after 5 writes with start held high
    n_strobe = 0; n_done = 0;
    mode = 3'd0; base = 16'h2000; len = 14'd20; fill = 8'h00; lane = 2'b11;
    push_run(0, 16'h2000, 5, 8'h00, 2'b11);
    @(negedge clk); start = 1'b1;
    c = 0;
    while (n_strobe < 5 && c < 100) begin @(negedge clk); #1; c++; end
    check("abort_reach5", n_strobe, 5);
    abort = 1'b1; base = 16'h3000; len = 14'd6;
    push_run(0, 16'h3000, 6, 8'h00, 2'b11);
    @(negedge clk); #1;
    abort = 1'b0;
    check("abort_idle", busy, 0);
    @(negedge clk); #1;
    check("restart_busy", busy, 1);
    check("abort_no_done", n_done, 0);
    start = 1'b0;
    wait_done("abort_restart_done");
    check("abort_strobes", n_strobe, 11);
    // reset mid-fill in LFSR mode, then fresh run with zero seed
    @(negedge clk); #1;
    n_strobe = 0;
    fill_go(3'd4, 16'h4000, 14'd10, 8'h5A, 2'b11, 3);
    c = 0;
    while (n_strobe < 3 && c < 100) begin @(negedge clk); #1; c++; end
    rst_n = 1'b0;
    #1;
    check("midrst_wr_n", wr_n, 1);
    check("midrst_outs", {addr, data, up_n, lo_n, busy, done}, 28'h000000C);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_reset_quiet", n_strobe, 3);
    check("post_reset_drain", exp_q.size(), 0);
    fill_go(3'd4, 16'h5000, 14'd8, 8'h00, 2'b11, 8);
    wait_done("lfsr_done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
